// File: rtl/adc_cbuf_pkg.sv
// rtl/adc_cbuf_pkg.sv - shared defaults and state encoding for the ADC circular-buffer trigger capture
package adc_cbuf_pkg;

    localparam int ADDR_W_DEF   = 12;
    localparam int PRE_TRIG_DEF = 256;
    localparam int WIN_LEN_DEF  = 1024;
    localparam int FIFO_AW_DEF  = 4;

    // One-hot: bit 0 IDLE, bit 1 PRIME, bit 2 ARMED, bit 3 HOLDOFF
    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_PRIME   = 4'b0010,
        ST_ARMED   = 4'b0100,
        ST_HOLDOFF = 4'b1000
    } cap_state_t;

endpackage

// File: rtl/trig_addr_fifo.sv
// rtl/trig_addr_fifo.sv - synchronous first-word-fall-through FIFO holding buffer start addresses
module trig_addr_fifo #(
    parameter int WIDTH = 12,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam int DEPTH_I = 1 << AW;
    localparam logic [AW:0] DEPTH = (AW + 1)'(DEPTH_I);

    logic [WIDTH-1:0] mem [DEPTH_I];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count == DEPTH);
    assign empty = (count == '0);
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;
    // Storage is not reset, so the head is masked to keep dout at 0 while empty.
    assign dout  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/adc_cbuf_trig_capture.sv
// rtl/adc_cbuf_trig_capture.sv - ADC-domain circular buffer writer, trigger address capture and read pointer
module adc_cbuf_trig_capture
    import adc_cbuf_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int PRE_TRIG = PRE_TRIG_DEF,
    parameter int WIN_LEN  = WIN_LEN_DEF,
    parameter int FIFO_AW  = FIFO_AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              acq_armed,
    input  logic              acq_trig,
    input  logic [31:0]       adc_dat,
    output logic              cbuf_wr_en,
    output logic [ADDR_W-1:0] cbuf_wr_addr,
    output logic [31:0]       cbuf_wr_dat,
    input  logic              trig_addr_rd_en,
    output logic [ADDR_W-1:0] trig_addr_dout,
    output logic              trig_addr_empty,
    input  logic              init_circ_buf_rd_addr,
    input  logic              inc_circ_buf_rd_addr,
    output logic [ADDR_W-1:0] cbuf_rd_addr,
    output logic              trig_overflow,
    output logic [15:0]       trig_drop_cnt
);

    localparam int PRIME_W = ADDR_W + 1;
    localparam int HOLD_W  = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam logic [ADDR_W-1:0]  PRE_OFS    = ADDR_W'(PRE_TRIG);
    localparam logic [PRIME_W-1:0] PRIME_LEN  = PRIME_W'(PRE_TRIG);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(WIN_LEN - 1);
    localparam logic [FIFO_AW:0]   FIFO_DEPTH = (FIFO_AW + 1)'(1 << FIFO_AW);

    cap_state_t         state;
    cap_state_t         state_nxt;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [PRIME_W-1:0] prime_cnt;
    logic [PRIME_W-1:0] prime_cnt_nxt;
    logic [PRIME_W-1:0] prime_inc;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [HOLD_W-1:0]  hold_cnt_nxt;
    logic               acq_trig_d1;
    logic               trig_edge;
    logic               trig_push;
    logic               trig_drop;
    logic               push_q;
    logic [ADDR_W-1:0]  push_addr_q;
    logic [FIFO_AW:0]   fifo_count;
    logic               fifo_full;

    assign trig_edge = acq_trig & ~acq_trig_d1;
    assign prime_inc = prime_cnt + 1'b1;
    assign fifo_full = (fifo_count == FIFO_DEPTH);

    // wr_ptr is the address the current cycle's word will be written to.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            cbuf_wr_en   <= 1'b0;
            cbuf_wr_addr <= '0;
            cbuf_wr_dat  <= '0;
            acq_trig_d1  <= 1'b0;
        end else begin
            cbuf_wr_en   <= acq_armed;
            cbuf_wr_addr <= wr_ptr;
            cbuf_wr_dat  <= adc_dat;
            acq_trig_d1  <= acq_trig;
            if (acq_armed) wr_ptr <= wr_ptr + 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        prime_cnt_nxt = prime_cnt;
        hold_cnt_nxt  = hold_cnt;
        trig_push     = 1'b0;
        trig_drop     = 1'b0;
        if (!acq_armed) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state_nxt     = ST_PRIME;
                    prime_cnt_nxt = '0;
                end
                ST_PRIME: begin
                    prime_cnt_nxt = prime_inc;
                    if (prime_inc >= PRIME_LEN) state_nxt = ST_ARMED;
                end
                ST_ARMED: begin
                    if (trig_edge) begin
                        if (fifo_full) begin
                            trig_drop = 1'b1;
                        end else begin
                            trig_push    = 1'b1;
                            hold_cnt_nxt = '0;
                            state_nxt    = ST_HOLDOFF;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (hold_cnt == HOLD_LAST) state_nxt = ST_ARMED;
                    else hold_cnt_nxt = hold_cnt + 1'b1;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            prime_cnt     <= '0;
            hold_cnt      <= '0;
            push_q        <= 1'b0;
            push_addr_q   <= '0;
            trig_overflow <= 1'b0;
            trig_drop_cnt <= '0;
        end else begin
            state       <= state_nxt;
            prime_cnt   <= prime_cnt_nxt;
            hold_cnt    <= hold_cnt_nxt;
            push_q      <= trig_push;
            // Modulo subtraction gives the wrapped buffer start address.
            push_addr_q <= wr_ptr - PRE_OFS;
            if (trig_drop) begin
                trig_overflow <= 1'b1;
                if (trig_drop_cnt != 16'hFFFF) trig_drop_cnt <= trig_drop_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cbuf_rd_addr <= '0;
        end else if (init_circ_buf_rd_addr) begin
            cbuf_rd_addr <= trig_addr_dout;
        end else if (inc_circ_buf_rd_addr) begin
            cbuf_rd_addr <= cbuf_rd_addr + 1'b1;
        end
    end

    trig_addr_fifo #(
        .WIDTH (ADDR_W),
        .AW    (FIFO_AW)
    ) u_trig_addr_fifo (
        .clk   (clk),
        .reset (reset),
        .wr_en (push_q),
        .din   (push_addr_q),
        .rd_en (trig_addr_rd_en),
        .dout  (trig_addr_dout),
        .empty (trig_addr_empty),
        .count (fifo_count)
    );

endmodule
